// File: rtl/ow_pkg.sv
// Shared 1-wire constants, state encoding and byte-select helpers for the
// DS18B20 responder and the master that talks to it.
package ow_pkg;

  localparam logic [7:0]  CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0]  CMD_READ_ROM = 8'h33;
  localparam logic [7:0]  CMD_CONVERT  = 8'h44;
  localparam logic [7:0]  CMD_READ_SCR = 8'hBE;
  localparam logic [7:0]  FAMILY_CODE  = 8'h28;
  localparam logic [15:0] TEMP_POR     = 16'h0550;

  localparam logic [7:0]  SCR_TH   = 8'h4B;
  localparam logic [7:0]  SCR_TL   = 8'h46;
  localparam logic [7:0]  SCR_CFG  = 8'h7F;
  localparam logic [7:0]  SCR_RES5 = 8'hFF;
  localparam logic [7:0]  SCR_RES6 = 8'h0C;
  localparam logic [7:0]  SCR_RES7 = 8'h10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRES_WAIT,
    ST_PRES_DRV,
    ST_ROM_RX,
    ST_FUNC_RX,
    ST_CONVERT,
    ST_TX_SCR,
    ST_TX_ROM
  } ow_state_e;

  // Byte 8 of the scratchpad is whatever the running CRC holds at that point.
  function automatic logic [7:0] scr_byte(input logic [3:0] idx, input logic [15:0] temp,
                                          input logic [7:0] crc);
    case (idx)
      4'd0:    return temp[7:0];
      4'd1:    return temp[15:8];
      4'd2:    return SCR_TH;
      4'd3:    return SCR_TL;
      4'd4:    return SCR_CFG;
      4'd5:    return SCR_RES5;
      4'd6:    return SCR_RES6;
      4'd7:    return SCR_RES7;
      default: return crc;
    endcase
  endfunction

  function automatic logic [7:0] rom_byte(input logic [3:0] idx, input logic [47:0] serial,
                                          input logic [7:0] crc);
    case (idx)
      4'd0:    return FAMILY_CODE;
      4'd1:    return serial[7:0];
      4'd2:    return serial[15:8];
      4'd3:    return serial[23:16];
      4'd4:    return serial[31:24];
      4'd5:    return serial[39:32];
      4'd6:    return serial[47:40];
      default: return crc;
    endcase
  endfunction

endpackage

// File: rtl/ow_crc8.sv
// Serial Dallas/Maxim CRC8 (x^8+x^5+x^4+1, reflected, init 0), one bit per enable.
module ow_crc8 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[0] ^ i_bit;
    if (i_clr) begin
      crc_d = 8'h00;
    end else if (i_en) begin
      crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/onewire_ds18b20_slave.sv
// DS18B20 1-wire responder: presence, Skip ROM, Convert T, Read Scratchpad.
// Define READ_ROM_EN to also answer Read ROM (0x33) with family code, ROM_SERIAL and CRC.
module onewire_ds18b20_slave
  import ow_pkg::*;
#(
  parameter int TICK_DIV    = 12,
  parameter int RST_MIN_US  = 440,
  parameter int PRES_DLY_US = 30,
  parameter int PRES_LEN_US = 120,
  parameter int SAMPLE_US   = 30,
  parameter int TX0_US      = 30,
  parameter int CONV_US     = 750000
`ifdef READ_ROM_EN
  , parameter logic [47:0] ROM_SERIAL = 48'h0000_0000_0001
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_owr,
  output logic        o_owr,
  input  logic [15:0] i_temp,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_valid,
  output logic        o_busy
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CONV_US > 1) ? $clog2(CONV_US) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_US - 1);
  localparam logic [15:0]   RST_T     = 16'(RST_MIN_US);
  localparam logic [15:0]   PDLY_T    = 16'(PRES_DLY_US);
  localparam logic [15:0]   PLEN_T    = 16'(PRES_LEN_US);
  localparam logic [15:0]   SAMP_T    = 16'(SAMPLE_US);
  localparam logic [15:0]   TX0_T     = 16'(TX0_US);

  logic            sync1_q, sync2_q, prev_q;
  logic            fall, rise, tick, accept;
  ow_state_e       state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [15:0]     t_q, t_d, low_q, low_d;
  logic [CW-1:0]   conv_q, conv_d;
  logic            drv_q, drv_d, slot_q, slot_d, armed_q, armed_d, busy_q, busy_d;
  logic [7:0]      cmd_q, cmd_d, sr_q, sr_d, rx_byte, tx_byte;
  logic            cmd_vld_q, cmd_vld_d;
  logic [15:0]     temp_q, temp_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d, crc_len;
  logic            crc_clr, crc_en, tx_bit;
  logic [7:0]      crc;

  assign fall    = prev_q & ~sync2_q;
  assign rise    = ~prev_q & sync2_q;
  assign tick    = (div_q == DIV_LAST);
  // Our own pull-down also produces a falling edge; only the master's starts a slot.
  assign accept  = fall & drv_q;
  assign rx_byte = {sync2_q, sr_q[7:1]};
  assign crc_len = (state_q == ST_TX_ROM) ? 4'd7 : 4'd8;

  ow_crc8 u_crc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (crc_clr),
    .i_en  (crc_en),
    .i_bit (tx_bit),
    .o_crc (crc)
  );

  always_comb begin
`ifdef READ_ROM_EN
    tx_byte = (state_q == ST_TX_ROM) ? rom_byte(byte_q, ROM_SERIAL, crc)
                                     : scr_byte(byte_q, temp_q, crc);
`else
    tx_byte = scr_byte(byte_q, temp_q, crc);
`endif
    tx_bit = (state_q == ST_CONVERT) ? ~busy_q : tx_byte[bit_q];
  end

  always_comb begin
    state_d   = state_q;
    drv_d     = drv_q;
    slot_d    = slot_q;
    armed_d   = armed_q;
    busy_d    = busy_q;
    cmd_d     = cmd_q;
    cmd_vld_d = 1'b0;
    temp_d    = temp_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    conv_d    = conv_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    div_d     = tick ? '0 : div_q + 1'b1;
    t_d       = (tick && t_q != 16'hFFFF) ? t_q + 16'd1 : t_q;
    low_d     = low_q;
    if (sync2_q || fall)              low_d = '0;
    else if (tick && low_q != RST_T)  low_d = low_q + 16'd1;
    if (accept) begin
      t_d   = '0;
      div_d = '0;
    end
    if (!drv_q && state_q != ST_PRES_DRV && t_q == TX0_T) drv_d = 1'b1;

    case (state_q)
      ST_PRES_WAIT: if (t_q == PDLY_T) begin
        state_d = ST_PRES_DRV;
        drv_d   = 1'b0;
        t_d     = '0;
        div_d   = '0;
      end
      ST_PRES_DRV: if (t_q == PLEN_T) begin
        state_d = ST_ROM_RX;
        drv_d   = 1'b1;
        slot_d  = 1'b0;
        bit_d   = '0;
      end
      ST_ROM_RX, ST_FUNC_RX: begin
        if (accept) begin
          slot_d = 1'b1;
        end else if (slot_q && t_q == SAMP_T) begin
          slot_d = 1'b0;
          sr_d   = rx_byte;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = '0;
            if (state_q == ST_ROM_RX) begin
              if (rx_byte == CMD_SKIP_ROM) state_d = ST_FUNC_RX;
`ifdef READ_ROM_EN
              else if (rx_byte == CMD_READ_ROM) begin
                state_d = ST_TX_ROM;
                crc_clr = 1'b1;
              end
`endif
              else state_d = ST_IDLE;
            end else begin
              cmd_d     = rx_byte;
              cmd_vld_d = 1'b1;
              if (rx_byte == CMD_CONVERT) begin
                state_d = ST_CONVERT;
                busy_d  = 1'b1;
                conv_d  = '0;
              end else if (rx_byte == CMD_READ_SCR) begin
                state_d = ST_TX_SCR;
                crc_clr = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      ST_CONVERT: if (accept && !tx_bit) drv_d = 1'b0;
      ST_TX_SCR, ST_TX_ROM: if (accept) begin
        if (!tx_bit) drv_d = 1'b0;
        crc_en = (byte_q < crc_len);
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_d = byte_q + 4'd1;
          if (byte_q == crc_len) begin
            byte_d  = '0;
            state_d = (state_q == ST_TX_SCR) ? ST_IDLE : ST_FUNC_RX;
          end
        end
      end
      default: ;
    endcase

    if (busy_q && tick) begin
      if (conv_q == CONV_LAST) begin
        busy_d = 1'b0;
        temp_d = i_temp;
      end else begin
        conv_d = conv_q + 1'b1;
      end
    end

    // Bus reset overrides everything above, including a conversion finishing this cycle.
    if (!sync2_q && low_q == RST_T) begin
      state_d = ST_IDLE;
      drv_d   = 1'b1;
      busy_d  = 1'b0;
      temp_d  = temp_q;
      conv_d  = '0;
      slot_d  = 1'b0;
      bit_d   = '0;
      byte_d  = '0;
      armed_d = 1'b1;
    end
    if (rise && armed_q) begin
      state_d = ST_PRES_WAIT;
      armed_d = 1'b0;
      t_d     = '0;
      div_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      div_q     <= '0;
      t_q       <= '0;
      low_q     <= '0;
      conv_q    <= '0;
      drv_q     <= 1'b1;
      slot_q    <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      cmd_q     <= 8'h00;
      cmd_vld_q <= 1'b0;
      temp_q    <= TEMP_POR;
      sr_q      <= 8'h00;
      bit_q     <= '0;
      byte_q    <= '0;
    end else begin
      sync1_q   <= i_owr;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      div_q     <= div_d;
      t_q       <= t_d;
      low_q     <= low_d;
      conv_q    <= conv_d;
      drv_q     <= drv_d;
      slot_q    <= slot_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      temp_q    <= temp_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
    end
  end

  assign o_owr       = drv_q;
  assign o_cmd       = cmd_q;
  assign o_cmd_valid = cmd_vld_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_onewire_ds18b20_slave.sv
// Bench acting as a 1-wire master (1 us = 2 clocks) against the DS18B20 responder.
`timescale 1ns/1ps
module tb_onewire_ds18b20_slave;

  localparam int US = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_drv;
  logic        bus;
  logic        o_owr;
  logic [15:0] i_temp;
  logic [7:0]  o_cmd;
  logic        o_cmd_valid;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  always #5 clk = ~clk;
  assign bus = m_drv & o_owr;

  onewire_ds18b20_slave #(.TICK_DIV(2), .CONV_US(200)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_owr       (bus),
    .o_owr       (o_owr),
    .i_temp      (i_temp),
    .o_cmd       (o_cmd),
    .o_cmd_valid (o_cmd_valid),
    .o_busy      (o_busy)
  );

  always @(posedge clk) if (o_cmd_valid) vcount <= vcount + 1;

  typedef struct {
    logic        conv;
    logic [15:0] temp;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-oriented reflected Dallas CRC8.
  function automatic logic [7:0] crc_model(input logic [63:0] bytes, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ bytes[i*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  task automatic ow_reset(input string name);
    logic ok;
    ok = 1'b1;
    m_drv = 1'b0;
    #(480*US);
    m_drv = 1'b1;
    #(26*US);  if (o_owr !== 1'b1) ok = 1'b0;
    #(8*US);   if (o_owr !== 1'b0) ok = 1'b0;
    #(112*US); if (o_owr !== 1'b0) ok = 1'b0;
    #(8*US);   if (o_owr !== 1'b1) ok = 1'b0;
    #(46*US);
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wr_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      m_drv = 1'b0;
      if (v[i]) begin #(1*US); m_drv = 1'b1; #(61*US); end
      else      begin #(60*US); m_drv = 1'b1; #(2*US); end
    end
  endtask

  task automatic rd_bit(output logic b);
    m_drv = 1'b0;
    #(2*US);
    m_drv = 1'b1;
    #(13*US);
    b = bus;
    #(25*US);
  endtask

  task automatic rd_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      v[i] = b;
    end
  endtask

  task automatic read_scratch(input logic [63:0] exp, input string tag);
    logic [7:0]  got;
    logic [63:0] seen;
    for (int i = 0; i < 8; i++) begin
      rd_byte(got);
      seen[i*8 +: 8] = got;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i*8 +: 8]});
    end
    rd_byte(got);
    chk($sformatf("%s_crc", tag), {24'd0, got}, {24'd0, crc_model(exp, 8)});
    chk($sformatf("%s_crc_vs_seen", tag), {24'd0, got}, {24'd0, crc_model(seen, 8)});
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        b;
    logic [7:0]  by;
    logic [19:0] bits20;
    logic [15:0] bits16;
    int          vc0, zeros;
    logic        got1;

    vecs[0] = '{1'b0, 16'h1234, 64'h100C_FF7F_464B_0550};
    vecs[1] = '{1'b1, 16'h0191, 64'h100C_FF7F_464B_0191};
    vecs[2] = '{1'b1, 16'hFC90, 64'h100C_FF7F_464B_FC90};

    m_drv  = 1'b1;
    rst_n  = 1'b0;
    i_temp = 16'h1234;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_owr",   {31'd0, o_owr},       32'd1);
    chk("rst_cmd",   {24'd0, o_cmd},       32'd0);
    chk("rst_valid", {31'd0, o_cmd_valid}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy},      32'd0);

    for (int v = 0; v < 3; v++) begin
      i_temp = vecs[v].temp;
      if (vecs[v].conv) begin
        ow_reset($sformatf("v%0d_pres_conv", v));
        wr_byte(8'hCC);
        vc0 = vcount;
        wr_byte(8'h44);
        chk($sformatf("v%0d_cmd44", v), {24'd0, o_cmd}, 32'h44);
        chk($sformatf("v%0d_one_pulse", v), vcount - vc0, 32'd1);
        chk($sformatf("v%0d_busy_set", v), {31'd0, o_busy}, 32'd1);
        rd_bit(b);
        chk($sformatf("v%0d_busy_slot0", v), {31'd0, b}, 32'd0);
        zeros = 1;
        got1  = 1'b0;
        for (int k = 0; k < 20 && !got1; k++) begin
          rd_bit(b);
          if (b) got1 = 1'b1;
          else   zeros++;
        end
        chk($sformatf("v%0d_conv_done_slot", v), {31'd0, got1}, 32'd1);
        chk($sformatf("v%0d_zero_slots_4to6", v), {31'd0, (zeros >= 4 && zeros <= 6)}, 32'd1);
        chk($sformatf("v%0d_busy_clear", v), {31'd0, o_busy}, 32'd0);
        i_temp = 16'hDEAD;
      end
      ow_reset($sformatf("v%0d_pres_read", v));
      wr_byte(8'hCC);
      wr_byte(8'hBE);
      chk($sformatf("v%0d_cmdBE", v), {24'd0, o_cmd}, 32'hBE);
      read_scratch(vecs[v].exp, $sformatf("v%0d", v));
    end

    // Reset after 20 of 72 scratchpad bits; the next read must restart at byte 0.
    ow_reset("abort_pres1");
    wr_byte(8'hCC);
    wr_byte(8'hBE);
    for (int i = 0; i < 20; i++) begin
      rd_bit(b);
      bits20[i] = b;
    end
    chk("abort_first20", {12'd0, bits20}, {12'd0, vecs[2].exp[19:0]});
    ow_reset("abort_pres2");
    wr_byte(8'hCC);
    wr_byte(8'hBE);
    read_scratch(vecs[2].exp, "restart");

    // Unknown ROM command: responder must stay silent.
    ow_reset("unk_pres");
    wr_byte(8'hF0);
    for (int i = 0; i < 16; i++) begin
      rd_bit(b);
      bits16[i] = b;
    end
    chk("unk_silent", {16'd0, bits16}, 32'h0000_FFFF);
    chk("unk_cmd_kept", {24'd0, o_cmd}, 32'hBE);

    ow_reset("rom_pres");
    wr_byte(8'h33);
`ifdef READ_ROM_EN
    begin
      logic [63:0] rom_exp;
      rom_exp = 64'h0000_0000_0000_0128;
      for (int i = 0; i < 7; i++) begin
        rd_byte(by);
        chk($sformatf("rom_byte%0d", i), {24'd0, by}, {24'd0, rom_exp[i*8 +: 8]});
      end
      rd_byte(by);
      chk("rom_crc", {24'd0, by}, {24'd0, crc_model(rom_exp, 7)});
    end
`else
    for (int i = 0; i < 16; i++) begin
      rd_bit(b);
      bits16[i] = b;
    end
    chk("rom_cmd_unknown_silent", {16'd0, bits16}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
